// File: rtl/greenhouse_act_pkg.sv
// Shared types, widths and helpers for the greenhouse actuator sequencer.
package greenhouse_act_pkg;

   localparam int unsigned CNT_W  = 8;
   localparam int unsigned RT_W   = 16;
   localparam int unsigned NUM_CH = 3;

   localparam int unsigned CH_FAN = 0;
   localparam int unsigned CH_HUM = 1;
   localparam int unsigned CH_IRR = 2;

   typedef enum logic [2:0] {
      OFF_READY,
      ON_LOCK,
      ON_READY,
      OFF_LOCK,
      COOLDOWN
   } chan_state_t;

   // A lock counter is spent when it is already 0 or this tick takes it to 0.
   function automatic logic cnt_expired(input logic [CNT_W-1:0] cnt, input logic tick);
      return (cnt == '0) || (tick && (cnt == CNT_W'(1)));
   endfunction

   function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] cnt, input logic tick);
      return (tick && (cnt != '0)) ? cnt - CNT_W'(1) : cnt;
   endfunction

endpackage

// File: rtl/act_channel.sv
// One actuator channel: min-on/min-off lock FSM with optional max-run cooldown.
// Optional runtime counter output when ACT_RUNTIME_CNT_EN is defined.
module act_channel
   import greenhouse_act_pkg::*;
#(
   parameter int unsigned MIN_ON         = 16,
   parameter int unsigned MIN_OFF        = 16,
   parameter bit          HAS_MAXRUN     = 1'b0,
   parameter int unsigned MAX_ON         = 64,
   parameter int unsigned COOLDOWN_TICKS = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic req,
   input  logic grant,
   output logic on_req_c,
   output logic timeout_c,
   output logic drv
`ifdef ACT_RUNTIME_CNT_EN
   ,
   output logic [RT_W-1:0] runtime
`endif
);

   localparam int unsigned RUN_W = CNT_W + 1;

   chan_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] run_q, run_d;
   logic             drv_q, drv_d;
   logic             lock_done;
   logic             run_hit;

   // Turn-on wish: idle, or an off/cooldown lock that expires this cycle.
   assign on_req_c = req && ((state_q == OFF_READY) ||
                             (((state_q == OFF_LOCK) || (state_q == COOLDOWN)) &&
                              cnt_expired(cnt_q, tick)));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      run_d     = run_q;
      timeout_c = 1'b0;
      lock_done = cnt_expired(cnt_q, tick);
      run_hit   = HAS_MAXRUN && tick &&
                  (({1'b0, run_q} + RUN_W'(1)) >= RUN_W'(MAX_ON));

      if (drv_q && tick && (run_q != '1)) run_d = run_q + CNT_W'(1);

      case (state_q)
         OFF_READY: begin
            if (grant) begin
               state_d = ON_LOCK;
               cnt_d   = CNT_W'(MIN_ON);
            end
         end
         ON_LOCK: begin
            cnt_d = cnt_dec(cnt_q, tick);
            if (lock_done) begin
               if (req) begin
                  state_d = ON_READY;
               end else begin
                  state_d = OFF_LOCK;
                  cnt_d   = CNT_W'(MIN_OFF);
               end
            end
         end
         ON_READY: begin
            if (!req) begin
               state_d = OFF_LOCK;
               cnt_d   = CNT_W'(MIN_OFF);
            end
         end
         OFF_LOCK, COOLDOWN: begin
            cnt_d = cnt_dec(cnt_q, tick);
            if (lock_done) begin
               if (grant) begin
                  state_d = ON_LOCK;
                  cnt_d   = CNT_W'(MIN_ON);
               end else begin
                  state_d = OFF_READY;
               end
            end
         end
         default: begin
            state_d = OFF_READY;
            cnt_d   = '0;
         end
      endcase

      // Max-run timeout overrides the min-on lock.
      if (((state_q == ON_LOCK) || (state_q == ON_READY)) && run_hit) begin
         state_d   = COOLDOWN;
         cnt_d     = CNT_W'(COOLDOWN_TICKS);
         timeout_c = 1'b1;
      end

      if ((state_d == ON_LOCK) && (state_q != ON_LOCK)) run_d = '0;

      drv_d = (state_d == ON_LOCK) || (state_d == ON_READY);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= OFF_READY;
         cnt_q   <= '0;
         run_q   <= '0;
         drv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         run_q   <= run_d;
         drv_q   <= drv_d;
      end
   end

   assign drv = drv_q;

`ifdef ACT_RUNTIME_CNT_EN
   logic [RT_W-1:0] runtime_q, runtime_d;

   always_comb begin
      runtime_d = runtime_q;
      if (drv_q && tick && (runtime_q != '1)) runtime_d = runtime_q + RT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst) runtime_q <= '0;
      else      runtime_q <= runtime_d;
   end

   assign runtime = runtime_q;
`endif

endmodule

// File: rtl/actuator_sequencer.sv
// Turns monitor requests into safe actuator drives: staggered turn-on, lock times,
// irrigation max-run cooldown and a sticky alarm. ACT_RUNTIME_CNT_EN adds runtime outputs.
module actuator_sequencer
   import greenhouse_act_pkg::*;
#(
   parameter int unsigned MIN_ON       = 16,
   parameter int unsigned MIN_OFF      = 16,
   parameter int unsigned IRR_MAX_ON   = 64,
   parameter int unsigned IRR_COOLDOWN = 32,
   parameter int unsigned STAGGER      = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic fan_req,
   input  logic irr_req,
   input  logic hum_req,
   input  logic alert_in,
   input  logic alert_ack,
   output logic fan_drv,
   output logic irr_drv,
   output logic hum_drv,
   output logic alarm_latched,
   output logic irr_timeout
`ifdef ACT_RUNTIME_CNT_EN
   ,
   output logic [RT_W-1:0] fan_runtime,
   output logic [RT_W-1:0] irr_runtime,
   output logic [RT_W-1:0] hum_runtime
`endif
);

   logic [NUM_CH-1:0] req_c, on_req_c, grant_c, drv_w, timeout_w;
   logic [CNT_W-1:0]  stagger_q, stagger_d;
   logic              alarm_q, alarm_d;
   logic              timeout_q, timeout_d;

   assign req_c[CH_FAN] = fan_req;
   assign req_c[CH_HUM] = hum_req;
   assign req_c[CH_IRR] = irr_req;

   act_channel #(
      .MIN_ON(MIN_ON), .MIN_OFF(MIN_OFF), .HAS_MAXRUN(1'b0),
      .MAX_ON(IRR_MAX_ON), .COOLDOWN_TICKS(IRR_COOLDOWN)
   ) u_fan (
      .clk(clk), .rst(rst), .tick(tick), .req(req_c[CH_FAN]), .grant(grant_c[CH_FAN]),
      .on_req_c(on_req_c[CH_FAN]), .timeout_c(timeout_w[CH_FAN]), .drv(drv_w[CH_FAN])
`ifdef ACT_RUNTIME_CNT_EN
      , .runtime(fan_runtime)
`endif
   );

   act_channel #(
      .MIN_ON(MIN_ON), .MIN_OFF(MIN_OFF), .HAS_MAXRUN(1'b0),
      .MAX_ON(IRR_MAX_ON), .COOLDOWN_TICKS(IRR_COOLDOWN)
   ) u_hum (
      .clk(clk), .rst(rst), .tick(tick), .req(req_c[CH_HUM]), .grant(grant_c[CH_HUM]),
      .on_req_c(on_req_c[CH_HUM]), .timeout_c(timeout_w[CH_HUM]), .drv(drv_w[CH_HUM])
`ifdef ACT_RUNTIME_CNT_EN
      , .runtime(hum_runtime)
`endif
   );

   act_channel #(
      .MIN_ON(MIN_ON), .MIN_OFF(MIN_OFF), .HAS_MAXRUN(1'b1),
      .MAX_ON(IRR_MAX_ON), .COOLDOWN_TICKS(IRR_COOLDOWN)
   ) u_irr (
      .clk(clk), .rst(rst), .tick(tick), .req(req_c[CH_IRR]), .grant(grant_c[CH_IRR]),
      .on_req_c(on_req_c[CH_IRR]), .timeout_c(timeout_w[CH_IRR]), .drv(drv_w[CH_IRR])
`ifdef ACT_RUNTIME_CNT_EN
      , .runtime(irr_runtime)
`endif
   );

   // Single fixed-priority turn-on grant once the stagger window is spent.
   always_comb begin
      grant_c = '0;
      if (cnt_expired(stagger_q, tick)) begin
         if (on_req_c[CH_FAN])      grant_c[CH_FAN] = 1'b1;
         else if (on_req_c[CH_HUM]) grant_c[CH_HUM] = 1'b1;
         else if (on_req_c[CH_IRR]) grant_c[CH_IRR] = 1'b1;
      end
   end

   always_comb begin
      stagger_d = (|grant_c) ? CNT_W'(STAGGER) : cnt_dec(stagger_q, tick);
      alarm_d   = alarm_q;
      timeout_d = timeout_q;
      if (alert_ack && !alert_in) begin
         alarm_d   = 1'b0;
         timeout_d = 1'b0;
      end
      if (|timeout_w) begin
         timeout_d = 1'b1;
         alarm_d   = 1'b1;
      end
      if (alert_in) alarm_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         stagger_q <= '0;
         alarm_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         stagger_q <= stagger_d;
         alarm_q   <= alarm_d;
         timeout_q <= timeout_d;
      end
   end

   assign fan_drv       = drv_w[CH_FAN];
   assign hum_drv       = drv_w[CH_HUM];
   assign irr_drv       = drv_w[CH_IRR];
   assign alarm_latched = alarm_q;
   assign irr_timeout   = timeout_q;

endmodule
